// File: rtl/kernel_job_scheduler_pkg.sv
// Shared definitions for the kernel job scheduler: FSM encoding, default sizes,
// and a popcount helper for the completion counter.
package kjs_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_KERNEL_NUM = 8;
    localparam int DEF_JOB_ID_W   = 16;
    localparam int DEF_CNT_W      = 32;

    // KERNEL_NUM is capped at 16, so callers zero-extend their vector to 16 bits
    function automatic logic [4:0] popcnt16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
        return c;
    endfunction
endpackage

// File: rtl/kernel_job_scheduler_arbiter.sv
// Combinational round-robin picker: first non-busy kernel at or after i_rr_ptr,
// wrapping modulo N.
module rr_idle_arbiter
    import kjs_pkg::*;
#(
    parameter int N     = DEF_KERNEL_NUM,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     i_busy,
    input  logic [PTR_W-1:0] i_rr_ptr,
    output logic             o_grant_valid,
    output logic [N-1:0]     o_grant_onehot,
    output logic [PTR_W-1:0] o_grant_idx
);
    always_comb begin
        int j;
        j              = 0;
        o_grant_valid  = 1'b0;
        o_grant_onehot = '0;
        o_grant_idx    = '0;
        // Walk from the farthest offset back to the pointer so the nearest idle kernel wins
        for (int i = N - 1; i >= 0; i--) begin
            j = (int'(i_rr_ptr) + i) % N;
            if (!i_busy[j]) begin
                o_grant_valid  = 1'b1;
                o_grant_onehot = '0;
                o_grant_onehot[j] = 1'b1;
                o_grant_idx    = PTR_W'(j);
            end
        end
    end
endmodule

// File: rtl/kernel_job_scheduler.sv
// Dispatches jobs round-robin onto idle kernels, tracks busy state from completion
// edges, and reports run progress and completion.
module kernel_job_scheduler
    import kjs_pkg::*;
#(
    parameter int KERNEL_NUM = DEF_KERNEL_NUM,
    parameter int JOB_ID_W   = DEF_JOB_ID_W,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  manager_start,
    input  logic                  run_mode,
    input  logic [CNT_W-1:0]      job_total,
    input  logic                  job_req_valid,
    input  logic [JOB_ID_W-1:0]   job_req_id,
    output logic                  job_req_ready,
    output logic [KERNEL_NUM-1:0] kernel_start,
    output logic [JOB_ID_W-1:0]   kernel_job_id,
    input  logic [KERNEL_NUM-1:0] kernel_complete,
    output logic [KERNEL_NUM-1:0] kernel_busy,
    output logic [CNT_W-1:0]      jobs_dispatched,
    output logic [CNT_W-1:0]      jobs_completed,
    output logic                  all_done,
    output logic                  aborted,
    output logic                  err_spurious
);
    localparam int PTR_W = $clog2(KERNEL_NUM);

    state_t                r_state;
    logic                  r_mode;
    logic [CNT_W-1:0]      r_total, r_disp, r_comp;
    logic [KERNEL_NUM-1:0] r_busy, r_complete_prev, r_start;
    logic [PTR_W-1:0]      r_rr_ptr;
    logic [JOB_ID_W-1:0]   r_job_id;
    logic                  r_all_done, r_aborted, r_err;

    logic                  w_grant_valid;
    logic [KERNEL_NUM-1:0] w_grant_onehot, w_edge, w_done, w_spur;
    logic [PTR_W-1:0]      w_grant_idx, w_ptr_nxt;
    logic [4:0]            w_done_cnt;
    logic                  w_below, w_ready, w_accept;
    logic [CNT_W:0]        w_disp_sum, w_comp_sum;
    logic [CNT_W-1:0]      w_disp_nxt, w_comp_nxt;

    rr_idle_arbiter #(.N(KERNEL_NUM), .PTR_W(PTR_W)) u_arb (
        .i_busy         (r_busy),
        .i_rr_ptr       (r_rr_ptr),
        .o_grant_valid  (w_grant_valid),
        .o_grant_onehot (w_grant_onehot),
        .o_grant_idx    (w_grant_idx)
    );

    assign w_edge     = kernel_complete & ~r_complete_prev;
    assign w_done     = w_edge & r_busy;
    assign w_spur     = w_edge & ~r_busy;
    assign w_done_cnt = popcnt16(16'(w_done));

    // Grant eligibility uses registered busy only; a kernel finishing now is eligible next cycle
    assign w_below  = r_disp < r_total;
    assign w_ready  = (r_state == ST_RUN) && w_grant_valid && (r_mode || w_below);
    assign w_accept = job_req_valid && w_ready;
    assign w_ptr_nxt = (w_grant_idx == PTR_W'(KERNEL_NUM - 1)) ? '0 : w_grant_idx + 1'b1;

    // Saturating counters: carry-out pins the value at all ones
    assign w_disp_sum = {1'b0, r_disp} + (CNT_W+1)'(w_accept);
    assign w_comp_sum = {1'b0, r_comp} + (CNT_W+1)'(w_done_cnt);
    assign w_disp_nxt = w_disp_sum[CNT_W] ? '1 : w_disp_sum[CNT_W-1:0];
    assign w_comp_nxt = w_comp_sum[CNT_W] ? '1 : w_comp_sum[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_mode          <= 1'b0;
            r_total         <= '0;
            r_disp          <= '0;
            r_comp          <= '0;
            r_busy          <= '0;
            r_complete_prev <= '1;
            r_start         <= '0;
            r_rr_ptr        <= '0;
            r_job_id        <= '0;
            r_all_done      <= 1'b0;
            r_aborted       <= 1'b0;
            r_err           <= 1'b0;
        end else begin
            r_complete_prev <= kernel_complete;
            r_busy          <= (r_busy & ~w_done) | (w_accept ? w_grant_onehot : '0);
            r_start         <= w_accept ? w_grant_onehot : '0;
            r_disp          <= w_disp_nxt;
            r_comp          <= w_comp_nxt;
            if (w_accept) begin
                r_job_id <= job_req_id;
                r_rr_ptr <= w_ptr_nxt;
            end
            if (|w_spur) r_err <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (manager_start && (run_mode || job_total != '0)) begin
                        r_state   <= ST_RUN;
                        r_mode    <= run_mode;
                        r_total   <= job_total;
                        r_rr_ptr  <= '0;
                        r_disp    <= '0;
                        r_comp    <= '0;
                        r_aborted <= 1'b0;
                        r_err     <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!manager_start) begin
                        r_state   <= ST_DRAIN;
                        r_aborted <= !r_mode && w_below;
                    end else if (!r_mode && !w_below) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_busy == '0) begin
                        r_state    <= ST_DONE;
                        r_all_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!manager_start) begin
                        r_state    <= ST_IDLE;
                        r_all_done <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign job_req_ready   = w_ready;
    assign kernel_start    = r_start;
    assign kernel_job_id   = r_job_id;
    assign kernel_busy     = r_busy;
    assign jobs_dispatched = r_disp;
    assign jobs_completed  = r_comp;
    assign all_done        = r_all_done;
    assign aborted         = r_aborted;
    assign err_spurious    = r_err;
endmodule
